bm_disp_pack: RTL and testbench

Block-matching output packer that sits directly downstream of the uniqueness-ratio stage. It consumes the per-pixel best-match result (cost, disparity, sub-pixel fraction, uniqueness ratio). It applies the uniqueness and absolute-cost validity tests and forms a Q8.8 disparity per pixel. It packs four pixels per 64-bit word, buffers the words in a small FIFO and presents them as an AXI4-Stream master with row/frame markers.

---
 rtl/bm_disp_pack.sv | 169 ++++++++++++++++
 tb/tb_bm_disp_pack.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_disp_pack.sv
// Block-matching output packer: validity test, Q8.8 disparity, 4-pixel packing, FWFT FIFO, AXI4-Stream master.
// Optional invalid-pixel statistics are enabled by defining BM_DISP_STATS_EN.
module bm_disp_pack #(
  parameter int IMG_W      = 640,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [10:0] img_h,
  input  logic        uni_on,
  input  logic [9:0]  uni_thresh,
  input  logic [15:0] max_cost,
  input  logic        vin,
  input  logic        upd_in,
  input  logic [15:0] min1_in,
  input  logic [7:0]  disp1_in,
  input  logic [7:0]  frac_in,
  input  logic [9:0]  uni_ratio,
  output logic [63:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        frame_done,
  output logic        overflow,
  output logic [19:0] invalid_cnt
);

  localparam int CW = $clog2(IMG_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic        d_vld, d_inv;
  logic [15:0] d_pix;
  logic        pix_ok;

  logic [1:0]    lane;
  logic [CW-1:0] col;
  logic [10:0]   row;
  logic [10:0]   img_h_q;
  logic [47:0]   hold;
  logic          tuser_arm;

  logic          take, word_done, row_end, final_word, wr_ok, pop, full, empty;
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic [65:0]   mem [FIFO_DEPTH];
  logic [65:0]   head;

  assign pix_ok = upd_in && (min1_in <= max_cost) && (!uni_on || (uni_ratio <= uni_thresh));

  // Decision register; a pixel arriving with frame_start belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_vld <= 1'b0;
      d_inv <= 1'b0;
      d_pix <= '0;
    end else begin
      d_vld <= vin && (frame_start || state == RUN);
      if (vin) begin
        d_pix <= pix_ok ? {disp1_in, frac_in} : 16'h0000;
        d_inv <= !pix_ok;
      end
    end
  end

  // A pixel still in the decision register when frame_start hits belongs to the abandoned frame.
  assign take       = d_vld && (state == RUN) && !frame_start;
  assign word_done  = take && (lane == 2'd3);
  assign row_end    = (col == COL_LAST);
  assign final_word = word_done && row_end && (row == img_h_q - 11'd1);

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = m_tvalid && m_tready;
  assign wr_ok = word_done && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane       <= '0;
      col        <= '0;
      row        <= '0;
      img_h_q    <= '0;
      hold       <= '0;
      tuser_arm  <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        state     <= RUN;
        lane      <= '0;
        col       <= '0;
        row       <= '0;
        img_h_q   <= img_h;
        hold      <= '0;
        tuser_arm <= 1'b1;
        overflow  <= 1'b0;
      end else if (take) begin
        lane <= lane + 2'd1;
        hold <= {d_pix, hold[47:16]};
        col  <= row_end ? '0 : col + CW'(1);
        if (row_end)
          row <= row + 11'd1;
        if (wr_ok)
          tuser_arm <= 1'b0;
        if (word_done && full && !pop)
          overflow <= 1'b1;
        if (final_word) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr[AW-1:0]] <= {row_end, tuser_arm, d_pix, hold};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Outputs are gated to zero while empty so a reset shows all-zero outputs immediately.
  assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign m_tvalid = !empty;
  assign m_tlast  = head[65];
  assign m_tuser  = head[64];
  assign m_tdata  = head[63:0];

`ifdef BM_DISP_STATS_EN
  logic [19:0] inv_acc, inv_next;

  always_comb begin
    inv_next = inv_acc;
    if (take && d_inv && (inv_acc != 20'hFFFFF))
      inv_next = inv_acc + 20'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_acc     <= '0;
      invalid_cnt <= '0;
    end else begin
      inv_acc <= frame_start ? '0 : inv_next;
      if (final_word)
        invalid_cnt <= inv_next;
    end
  end
`else
  assign invalid_cnt = '0;
`endif

endmodule

// File: tb/tb_bm_disp_pack.sv
// Scoreboard bench for bm_disp_pack (IMG_W=8, FIFO_DEPTH=4); expected words come from a small packing model.
module tb_bm_disp_pack;

  localparam int IMG_W = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] img_h = '0;
  logic        uni_on = 1'b0;
  logic [9:0]  uni_thresh = '0;
  logic [15:0] max_cost = '0;
  logic        vin = 1'b0;
  logic        upd_in = 1'b0;
  logic [15:0] min1_in = '0;
  logic [7:0]  disp1_in = '0;
  logic [7:0]  frac_in = '0;
  logic [9:0]  uni_ratio = '0;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast, m_tuser, frame_done, overflow;
  logic [19:0] invalid_cnt;

  bm_disp_pack #(.IMG_W(IMG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .img_h(img_h),
    .uni_on(uni_on), .uni_thresh(uni_thresh), .max_cost(max_cost),
    .vin(vin), .upd_in(upd_in), .min1_in(min1_in), .disp1_in(disp1_in),
    .frac_in(frac_in), .uni_ratio(uni_ratio),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_done(frame_done),
    .overflow(overflow), .invalid_cnt(invalid_cnt)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount = 0;
  int popCount = 0;
  logic [65:0] expQ[$];
  logic [63:0] obsWords[$];

  logic [47:0] mHold;
  int mLane, mCol, mRow, mH, mInvalid, expInvalid;
  bit mRun, mUser;

  task automatic checkOutput(input string tag, input logic [65:0] actual, input logic [65:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  // Words are transferred at the next posedge; sampling on negedge sees stable handshake values.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      popCount++;
      obsWords.push_back(m_tdata);
      if (expQ.size() == 0)
        checkOutput("unexpected_word", 66'd1, 66'd0);
      else
        checkOutput("word", {m_tlast, m_tuser, m_tdata}, expQ.pop_front());
    end
  end

  task automatic modelPixel(input logic [15:0] pix, input bit inv);
    if (mRun) begin
      if (inv) mInvalid++;
      if (mLane == 3) begin
        if (expQ.size() < DEPTH) begin
          expQ.push_back({(mCol == IMG_W - 1), mUser, pix, mHold});
          mUser = 1'b0;
        end
        if (mCol == IMG_W - 1 && mRow == mH - 1) begin
          mRun = 1'b0;
          expInvalid = mInvalid;
        end
      end else begin
        mHold = {pix, mHold[47:16]};
      end
      mLane = (mLane + 1) % 4;
      if (mCol == IMG_W - 1) begin
        mCol = 0;
        mRow++;
      end else begin
        mCol++;
      end
    end
  endtask

  task automatic applyStimulus(input bit upd, input logic [15:0] min1, input logic [7:0] disp,
                               input logic [7:0] frac, input logic [9:0] ratio, input bit uon);
    bit ok;
    vin = 1'b1; upd_in = upd; min1_in = min1; disp1_in = disp;
    frac_in = frac; uni_ratio = ratio; uni_on = uon;
    ok = upd && (min1 <= max_cost) && (!uon || ratio <= uni_thresh);
    modelPixel(ok ? {disp, frac} : 16'h0000, !ok);
    @(posedge clk); #1;
  endtask

  task automatic pulseFrameStart(input int h);
    frame_start = 1'b1;
    img_h = 11'(h);
    mLane = 0; mCol = 0; mRow = 0; mH = h; mHold = '0;
    mInvalid = 0; mRun = 1'b1; mUser = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", 66'(expQ.size()), 66'd0);
  endtask

  task automatic waitFrameDone(input int maxCycles);
    int n = 0;
    while (frame_done !== 1'b1 && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("frame_done_seen", 66'(frame_done), 66'd1);
  endtask

  initial begin
    int base;
    bit exp_stats;
    logic [65:0] headWord;
`ifdef BM_DISP_STATS_EN
    exp_stats = 1'b1;
`else
    exp_stats = 1'b0;
`endif
    mRun = 1'b0; mUser = 1'b0; mHold = '0;
    mLane = 0; mCol = 0; mRow = 0; mH = 1; mInvalid = 0; expInvalid = 0;

    #3;
    checkOutput("rst_tvalid", 66'(m_tvalid), 66'd0);
    checkOutput("rst_tdata", 66'(m_tdata), 66'd0);
    checkOutput("rst_flags", 66'({m_tlast, m_tuser, frame_done, overflow}), 66'd0);
    checkOutput("rst_invalid_cnt", 66'(invalid_cnt), 66'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic packing: disparity equals column, fraction 0x80
    max_cost = 16'hFFFF; uni_thresh = 10'd512; m_tready = 1'b1;
    base = obsWords.size();
    pulseFrameStart(2);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 16'd10, 8'(i % IMG_W), 8'h80, 10'd0, 1'b0);
    vin = 1'b0;
    checkOutput("done_early", 66'(frame_done), 66'd0);
    @(posedge clk); #1;
    checkOutput("done_2cyc", 66'(frame_done), 66'd1);
    @(posedge clk); #1;
    checkOutput("done_pulse", 66'(frame_done), 66'd0);
    waitDrain(10);
    checkOutput("basic_words", 66'(obsWords.size() - base), 66'd4);
    if (obsWords.size() > base)
      checkOutput("basic_word0", 66'(obsWords[base]), 66'h0380_0280_0180_0080);

    // Validity and statistics: 5 invalid pixels in an 8x2 frame
    max_cost = 16'd100;
    pulseFrameStart(2);
    applyStimulus(1'b1, 16'd50, 8'd11, 8'h10, 10'd513, 1'b1);
    applyStimulus(1'b1, 16'd50, 8'd12, 8'h20, 10'd512, 1'b1);
    applyStimulus(1'b1, 16'd101, 8'd13, 8'h30, 10'd0, 1'b1);
    applyStimulus(1'b0, 16'd50, 8'd14, 8'h40, 10'd0, 1'b1);
    applyStimulus(1'b1, 16'd100, 8'd15, 8'h50, 10'd1023, 1'b0);
    applyStimulus(1'b0, 16'd50, 8'd16, 8'h60, 10'd0, 1'b0);
    applyStimulus(1'b0, 16'd50, 8'd17, 8'h70, 10'd0, 1'b0);
    for (int i = 7; i < 16; i++)
      applyStimulus(1'b1, 16'(i), 8'(i + 20), 8'(i * 3), 10'(i), 1'b1);
    vin = 1'b0;
    waitFrameDone(10);
    checkOutput("invalid_cnt", 66'(invalid_cnt), exp_stats ? 66'(expInvalid) : 66'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 16'd1, 8'd99, 8'd1, 10'd0, 1'b0);
    vin = 1'b0;
    repeat (4) @(posedge clk);
    #1 waitDrain(10);

    // Backpressure: 20 words with the sink stalled
    m_tready = 1'b0;
    base = popCount;
    pulseFrameStart(10);
    for (int i = 0; i < 80; i++)
      applyStimulus(1'b1, 16'd5, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 10'd0, 1'b0);
    vin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovf_set", 66'(overflow), 66'd1);
    checkOutput("stall_valid", 66'(m_tvalid), 66'd1);
    headWord = (expQ.size() != 0) ? expQ[0] : '0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_stable", {m_tlast, m_tuser, m_tdata}, headWord);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    waitDrain(20);
    repeat (3) @(posedge clk);
    #1 checkOutput("bp_drained", 66'(popCount - base), 66'd4);
    pulseFrameStart(1);
    checkOutput("ovf_clear", 66'(overflow), 66'd0);

    // Restart in the middle of a frame with one word still queued
    m_tready = 1'b0;
    base = popCount;
    pulseFrameStart(2);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 16'd5, 8'(i + 40), 8'h11, 10'd0, 1'b0);
    vin = 1'b0;
    m_tready = 1'b1;
    pulseFrameStart(2);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 16'd5, 8'(i + 60), 8'h22, 10'd0, 1'b0);
    vin = 1'b0;
    waitDrain(20);
    checkOutput("restart_words", 66'(popCount - base), 66'd5);

    // Asynchronous reset with three words queued
    m_tready = 1'b0;
    pulseFrameStart(2);
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 16'd5, 8'(i), 8'h33, 10'd0, 1'b0);
    vin = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_tvalid", 66'(m_tvalid), 66'd0);
    checkOutput("arst_outputs", {m_tlast, m_tuser, m_tdata}, 66'd0);
    checkOutput("arst_flags", 66'({frame_done, overflow, invalid_cnt}), 66'd0);
    expQ.delete();
    mRun = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    base = popCount;
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 16'd5, 8'(i), 8'h44, 10'd0, 1'b0);
    vin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_ignored", 66'(popCount - base), 66'd0);
    checkOutput("idle_tvalid", 66'(m_tvalid), 66'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
